// File: rtl/ibus_imem_responder.sv
// ibus_imem_responder: iBus fetch responder returning words from a side-band loaded memory after a fixed wait-state latency
module ibus_imem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rstf,
  input  logic                     iBus_cmd_valid,
  output logic                     iBus_cmd_ready,
  input  logic [31:0]              iBus_cmd_payload_pc,
  output logic                     iBus_rsp_ready,
  output logic                     iBus_rsp_err,
  output logic [31:0]              iBus_rsp_inst,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [31:0]              ld_data
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d, inst_q, inst_d, rd_pc;
  logic err_q, err_d, accept, enter_resp, rd_err;
  logic [31:0] mem [DEPTH];
  assign iBus_cmd_ready = state_q != WAIT;
  assign iBus_rsp_ready = state_q == RESP;
  assign iBus_rsp_err = err_q;
  assign iBus_rsp_inst = inst_q;
  assign accept = iBus_cmd_valid & iBus_cmd_ready;
  // With LATENCY==1 the read happens on the accept edge itself, before pc_q holds the new pc
  assign rd_pc = accept ? iBus_cmd_payload_pc : pc_q;
  assign rd_err = (rd_pc[1:0] != 2'b00) || (rd_pc[31:2] >= 30'(DEPTH));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    pc_d = accept ? iBus_cmd_payload_pc : pc_q;
    if (accept) begin
      state_d = (LATENCY == 1) ? RESP : WAIT;
      cnt_d = 4'(LATENCY - 2);
    end else if (state_q == WAIT) begin
      state_d = (cnt_q == 4'd0) ? RESP : WAIT;
      cnt_d = (cnt_q == 4'd0) ? cnt_q : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    enter_resp = state_d == RESP;
    err_d = enter_resp ? rd_err : err_q;
    inst_d = enter_resp ? (rd_err ? 32'd0 : mem[rd_pc[2 +: AW]]) : inst_q;
  end
  always_ff @(posedge clk or negedge rstf) begin
    if (!rstf) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      pc_q <= 32'd0;
      err_q <= 1'b0;
      inst_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pc_q <= pc_d;
      err_q <= err_d;
      inst_q <= inst_d;
    end
  end
  // Write-before-read hazard resolves to old data: inst_d samples mem before this edge's write lands
  always_ff @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
  end
endmodule

// File: tb/tb_ibus_imem_responder.sv
// tb_ibus_imem_responder: three responders (LATENCY 1..3) against a queue scoreboard and a word-array memory model
module tb_ibus_imem_responder;
  localparam int DEPTH = 1024;
  localparam int AW = $clog2(DEPTH);
  logic clk = 1'b0;
  logic rstf;
  logic cmd_valid [3];
  logic cmd_ready [3];
  logic rsp_ready [3];
  logic rsp_err [3];
  logic [31:0] cmd_pc [3];
  logic [31:0] rsp_inst [3];
  logic ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_data;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int last_acc [3];
  logic [63:0] sbq [3][$];
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] boot [4];
  int lw_edge = -1;
  int lw_addr = 0;
  logic [31:0] lw_old = 32'd0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic cmp(string nm, int k, logic [31:0] act, logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", nm, k, cyc, act, want);
    end
  endtask

  // Instance k has LATENCY k+1: busy for k cycles after an accept, response due k edges later
  task automatic monitor(int k);
    logic [63:0] e;
    logic [31:0] pc, xi;
    logic xe;
    cmp("cmd_ready", k, 32'(cmd_ready[k]), 32'(cyc >= last_acc[k] + k));
    while (sbq[k].size() > 0 && int'(sbq[k][0][63:32]) < cyc) begin
      e = sbq[k].pop_front();
      checks++;
      errors++;
      $display("FAIL missed_rsp dut%0d cyc=%0d got=no_response expected=rsp_at_cyc%0d pc=%h", k, cyc, e[63:32], e[31:0]);
    end
    if (rsp_ready[k]) begin
      checks++;
      if (sbq[k].size() == 0) begin
        errors++;
        $display("FAIL stray_rsp dut%0d cyc=%0d got=rsp_ready expected=no_response", k, cyc);
      end else begin
        e = sbq[k].pop_front();
        pc = e[31:0];
        cmp("rsp_cycle", k, 32'(cyc), e[63:32]);
        xe = (pc % 4 != 0) || (pc >= 32'(4 * DEPTH));
        xi = xe ? 32'd0 : (lw_edge == cyc && lw_addr == int'(pc / 4)) ? lw_old : ref_mem[pc / 4];
        cmp("rsp_err", k, 32'(rsp_err[k]), 32'(xe));
        cmp("rsp_inst", k, rsp_inst[k], xi);
      end
    end
  endtask

  task automatic issue(int k, logic [31:0] pc);
    int n = 0;
    cmd_valid[k] = 1'b1;
    cmd_pc[k] = pc;
    @(negedge clk);
    while (!cmd_ready[k] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout dut%0d cyc=%0d got=cmd_ready_low expected=accept", k, cyc);
      cmd_valid[k] = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    last_acc[k] = cyc;
    sbq[k].push_back({32'(cyc + k), pc});
    cmd_valid[k] = 1'b0;
  endtask

  task automatic load(int a, logic [31:0] d);
    ld_en = 1'b1;
    ld_addr = AW'(a);
    ld_data = d;
    @(posedge clk);
    #1;
    lw_edge = cyc;
    lw_addr = a;
    lw_old = ref_mem[a];
    ref_mem[a] = d;
    ld_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n == 60) begin
      errors++;
      $display("FAIL drain cyc=%0d got=pending%0d expected=pending0", cyc, sbq[0].size() + sbq[1].size() + sbq[2].size());
    end
  endtask

  task automatic reset_check();
    for (int k = 0; k < 3; k++) begin
      cmp("rst_cmd_ready", k, 32'(cmd_ready[k]), 32'd1);
      cmp("rst_rsp_ready", k, 32'(rsp_ready[k]), 32'd0);
      cmp("rst_rsp_err", k, 32'(rsp_err[k]), 32'd0);
      cmp("rst_rsp_inst", k, rsp_inst[k], 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_pc();
    int r = int'($urandom_range(0, 9));
    if (r == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
    if (r == 1) return ($urandom_range(0, 1) != 0) ? 32'hFFFF_FFFC : 32'(4 * DEPTH + 4 * $urandom_range(0, 255));
    if (r < 6) return 32'(4 * $urandom_range(0, 15));
    return 32'(4 * $urandom_range(0, DEPTH - 1));
  endfunction

  task automatic rand_fetches(int k);
    repeat (30) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      issue(k, rand_pc());
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ibus_imem_responder #(.DEPTH(DEPTH), .LATENCY(g + 1)) dut (
      .clk(clk),
      .rstf(rstf),
      .iBus_cmd_valid(cmd_valid[g]),
      .iBus_cmd_ready(cmd_ready[g]),
      .iBus_cmd_payload_pc(cmd_pc[g]),
      .iBus_rsp_ready(rsp_ready[g]),
      .iBus_rsp_err(rsp_err[g]),
      .iBus_rsp_inst(rsp_inst[g]),
      .ld_en(ld_en),
      .ld_addr(ld_addr),
      .ld_data(ld_data)
    );
    always @(negedge clk) if (mon_en) monitor(g);
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout cyc=%0d got=still_running expected=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    boot[0] = 32'h0000_0013;
    boot[1] = 32'h0010_0093;
    boot[2] = 32'h0020_0113;
    boot[3] = 32'h0030_8193;
    rstf = 1'b1;
    ld_en = 1'b0;
    ld_addr = '0;
    ld_data = '0;
    for (int k = 0; k < 3; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_pc[k] = '0;
      last_acc[k] = -1000;
    end
    #2 rstf = 1'b0;
    #1 reset_check();
    @(negedge clk);
    rstf = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b1;
    for (int i = 0; i < DEPTH; i++) load(i, (i < 4) ? boot[i] : $urandom);
    issue(1, 32'h4);
    drain();
    for (int i = 0; i < 4; i++) issue(0, 32'(4 * i));
    drain();
    issue(1, 32'h2);
    issue(1, 32'(4 * DEPTH));
    drain();
    issue(2, 32'h10);
    issue(2, 32'h14);
    drain();
    issue(1, 32'h8);
    load(2, 32'hDEAD_BEEF);
    issue(1, 32'h8);
    drain();
    issue(2, 32'h4);
    rstf = 1'b0;
    #1 reset_check();
    for (int k = 0; k < 3; k++) begin
      sbq[k].delete();
      last_acc[k] = -1000;
    end
    @(negedge clk);
    rstf = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    issue(2, 32'hC);
    drain();
    fork
      rand_fetches(0);
      rand_fetches(1);
      rand_fetches(2);
      repeat (80) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        load(int'($urandom_range(0, 15)), $urandom);
      end
    join
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
